// File: rtl/word_matcher_pkg.sv
// word_matcher_pkg: shared types and constants for the word matcher.
// Holds the FSM state enum, history depth, end sentinel and length clamp.
package word_matcher_pkg;

    localparam int MAX_WORD = 8;
    localparam logic [7:0] END_SENTINEL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ARMED
    } state_t;

    // Effective word length: word_size saturated at the history depth.
    function automatic logic [3:0] clamp_len(input logic [7:0] ws);
        if (ws > 8'(MAX_WORD)) begin
            return 4'(MAX_WORD);
        end
        return ws[3:0];
    endfunction

endpackage

// File: rtl/match_compare.sv
// match_compare: combinational masked compare of the history window.
// Ports: i_hist (hist[0] newest), i_chars, i_masks, i_len -> o_match.
module match_compare
    import word_matcher_pkg::*;
(
    input  logic [MAX_WORD-1:0][7:0] i_hist,
    input  logic [8*MAX_WORD-1:0]    i_chars,
    input  logic [8*MAX_WORD-1:0]    i_masks,
    input  logic [3:0]               i_len,
    output logic                     o_match
);

    localparam int IW = $clog2(MAX_WORD);

    logic [MAX_WORD-1:0] w_hit;
    logic [IW-1:0]       w_idx;

    // Character i of the word lines up with hist[L-1-i];
    // positions at or beyond L are forced true.
    always_comb begin
        w_hit = '1;
        w_idx = '0;
        for (int i = 0; i < MAX_WORD; i++) begin
            if (4'(i) < i_len) begin
                w_idx = IW'(i_len - 4'd1 - 4'(i));
                w_hit[i] = ((i_hist[w_idx] ^ i_chars[8*i +: 8])
                            & i_masks[8*i +: 8]) == 8'h00;
            end
        end
    end

    assign o_match = &w_hit;

endmodule

// File: rtl/word_matcher.sv
// word_matcher: streaming matcher of a 1-8 char masked word, 2-edge latency.
// Ports: aclk/aresetn (sync low), word_size, result_mask, characters, masks,
//   s_axis_tvalid/tdata/tuser in, m_axis_tvalid/tdata out (no backpressure).
// Macro WORD_MATCHER_END_SENTINEL_EN: end beat emits one 0xFF result byte.
module word_matcher #(
    parameter int MAX_WORD = word_matcher_pkg::MAX_WORD
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [7:0]            word_size,
    input  logic [7:0]            result_mask,
    input  logic [8*MAX_WORD-1:0] characters,
    input  logic [8*MAX_WORD-1:0] masks,
    input  logic                  s_axis_tvalid,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tuser,
    output logic                  m_axis_tvalid,
    output logic [7:0]            m_axis_tdata
);

    import word_matcher_pkg::*;

    logic [MAX_WORD-1:0][7:0] r_hist;
    logic [3:0]               r_fill;
    logic [7:0]               r_pos;
    state_t                   r_state;
    logic                     r_char_s1;
    logic [7:0]               r_pos_s1;
`ifdef WORD_MATCHER_END_SENTINEL_EN
    logic                     r_end_s1;
`endif
    logic                     r_out_vld;
    logic [7:0]               r_out_data;

    logic                     w_char_beat;
    logic                     w_end_beat;
    logic [3:0]               w_len;
    logic [3:0]               w_fill_nxt;
    state_t                   w_state_nxt;
    logic                     w_match;
    logic                     w_hit;

    assign w_char_beat = s_axis_tvalid & ~s_axis_tuser;
    assign w_end_beat  = s_axis_tvalid & s_axis_tuser;
    assign w_len       = clamp_len(word_size);
    assign w_fill_nxt  = (r_fill == 4'(MAX_WORD)) ? r_fill
                                                  : r_fill + 4'd1;

    // Outside IDLE the state re-evaluates fill against the live length,
    // so a longer word drops ARMED back to FILL.
    always_comb begin
        w_state_nxt = r_state;
        unique case (1'b1)
            w_end_beat: begin
                w_state_nxt = IDLE;
            end
            w_char_beat: begin
                w_state_nxt = (w_fill_nxt >= w_len) ? ARMED : FILL;
            end
            default: begin
                if (r_state != IDLE) begin
                    w_state_nxt = (r_fill >= w_len) ? ARMED : FILL;
                end
            end
        endcase
    end

    match_compare u_cmp (
        .i_hist  (r_hist),
        .i_chars (characters),
        .i_masks (masks),
        .i_len   (w_len),
        .o_match (w_match)
    );

    // Fill is checked against the live length rather than the registered
    // state so config changes apply on the very next compared beat.
    assign w_hit = r_char_s1 && (r_state != IDLE) && (w_len != 4'd0)
                   && (r_fill >= w_len) && w_match;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_hist     <= '0;
            r_fill     <= '0;
            r_pos      <= '0;
            r_state    <= IDLE;
            r_char_s1  <= 1'b0;
            r_pos_s1   <= '0;
`ifdef WORD_MATCHER_END_SENTINEL_EN
            r_end_s1   <= 1'b0;
`endif
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_char_s1 <= w_char_beat;
`ifdef WORD_MATCHER_END_SENTINEL_EN
            r_end_s1  <= w_end_beat;
`endif
            if (w_end_beat) begin
                r_hist <= '0;
                r_fill <= '0;
                r_pos  <= '0;
            end else if (w_char_beat) begin
                r_hist   <= {r_hist[MAX_WORD-2:0], s_axis_tdata};
                r_fill   <= w_fill_nxt;
                r_pos_s1 <= r_pos;
                r_pos    <= r_pos + 8'd1;
            end

            r_out_vld <= 1'b0;
            if (w_hit) begin
                r_out_vld  <= 1'b1;
                r_out_data <= r_pos_s1 & result_mask;
            end
`ifdef WORD_MATCHER_END_SENTINEL_EN
            else if (r_end_s1) begin
                r_out_vld  <= 1'b1;
                r_out_data <= END_SENTINEL;
            end
`endif
        end
    end

    assign m_axis_tvalid = r_out_vld;
    assign m_axis_tdata  = r_out_data;

endmodule

// File: tb/tb_word_matcher.sv
// tb_word_matcher: table vectors, corner sequences and random stream
// checked against a queue-based reference model of the matcher.
module tb_word_matcher;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  word_size = 8'd0;
    logic [7:0]  result_mask = 8'hFF;
    logic [63:0] characters = '0;
    logic [63:0] masks = '0;
    logic        s_axis_tvalid = 1'b0;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tuser = 1'b0;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;

    word_matcher dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .word_size     (word_size),
        .result_mask   (result_mask),
        .characters    (characters),
        .masks         (masks),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        int         e;
        logic [7:0] d;
    } res_t;

    res_t got_q[$];
    res_t exp_q[$];
    int   ce[$];
    int   tests = 0;
    int   fails = 0;

    always @(negedge aclk) begin
        res_t r;
        if (m_axis_tvalid) begin
            r.e = cyc;
            r.d = m_axis_tdata;
            got_q.push_back(r);
        end
    end

    // Reference model: text since last end, plus a mod-256 position.
    logic [7:0] mtext[$];
    int         mpos = 0;

    function automatic void model_char(input logic [7:0] c, input int e);
        int   l;
        int   n;
        bit   ok;
        res_t r;
        int   idx;
        mtext.push_back(c);
        if (mtext.size() > 8) void'(mtext.pop_front());
        idx = mpos;
        mpos = (mpos + 1) % 256;
        l = (int'(word_size) > 8) ? 8 : int'(word_size);
        n = mtext.size();
        if (l > 0 && n >= l) begin
            ok = 1;
            for (int i = 0; i < l; i++) begin
                if (((mtext[n-l+i] ^ characters[8*i +: 8])
                     & masks[8*i +: 8]) != 8'h00) ok = 0;
            end
            if (ok) begin
                r.e = e + 1;
                r.d = 8'(idx) & result_mask;
                exp_q.push_back(r);
            end
        end
    endfunction

    function automatic void model_end(input int e);
        res_t r;
        mtext.delete();
        mpos = 0;
`ifdef WORD_MATCHER_END_SENTINEL_EN
        r.e = e + 1;
        r.d = 8'hFF;
        exp_q.push_back(r);
`else
        r.e = e;
`endif
    endfunction

    task automatic send(input logic user, input logic [7:0] d);
        int e;
        @(negedge aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = user;
        s_axis_tdata  = d;
        e = cyc + 1;
        if (user) begin
            model_end(e);
        end else begin
            ce.push_back(e);
            model_char(d, e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b0;
            s_axis_tuser  = 1'b0;
        end
    endtask

    task automatic flush();
        send(1'b1, 8'h00);
        idle(5);
        got_q.delete();
        exp_q.delete();
        ce.delete();
    endtask

    task automatic check(input string nm);
        int n;
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s: got %0d results, want %0d",
                     nm, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            tests++;
            if (got_q[i].e != exp_q[i].e || got_q[i].d != exp_q[i].d) begin
                fails++;
                $display("FAIL %s[%0d]: got edge %0d data %h, want edge %0d data %h",
                         nm, i, got_q[i].e, got_q[i].d,
                         exp_q[i].e, exp_q[i].d);
            end
        end
        got_q.delete();
        exp_q.delete();
        ce.delete();
    endtask

    function automatic logic [63:0] mkw(input logic [63:0] w, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = w[8*(n-1-i) +: 8];
        return r;
    endfunction

    typedef struct {
        logic [7:0]      ws;
        logic [63:0]     word;
        int              wn;
        logic [63:0]     mk;
        logic [7:0]      rm;
        logic [127:0]    txt;
        int              tn;
        int              en;
        logic [3:0][7:0] eidx;
        logic [3:0][7:0] edat;
    } vec_t;

    function automatic vec_t mkv(
        input logic [7:0] ws, input logic [63:0] w, input int wn,
        input logic [63:0] mk, input logic [7:0] rm,
        input logic [127:0] tx, input int tn, input int en,
        input logic [31:0] ei, input logic [31:0] ed);
        vec_t v;
        v.ws = ws; v.word = w; v.wn = wn; v.mk = mk; v.rm = rm;
        v.txt = tx; v.tn = tn; v.en = en; v.eidx = ei; v.edat = ed;
        return v;
    endfunction

    vec_t vt[7];

    initial begin
        res_t        r;
        logic [7:0]  ab[4];
        logic [7:0]  mopt[3];
        int          k;
        int          expn;

        vt[0] = mkv(8'd3, "abc", 3, {8{8'hFF}}, 8'hFF,
                    "xabcab", 6, 1, 32'h03, 32'h03);
        vt[1] = mkv(8'd2, "aa", 2, {8{8'hDF}}, 8'hFF,
                    "AaA", 3, 2, 32'h0201, 32'h0201);
        vt[2] = mkv(8'd0, "abcd", 4, {8{8'hFF}}, 8'hFF,
                    "abcdabcd", 8, 0, 32'h0, 32'h0);
        vt[3] = mkv(8'd12, "abcdefgh", 8, {8{8'hFF}}, 8'hFF,
                    "xabcdefghab", 11, 1, 32'h08, 32'h08);
        vt[4] = mkv(8'd1, "q", 1, 64'h0, 8'hFF,
                    "xyz", 3, 3, 32'h020100, 32'h020100);
        vt[5] = mkv(8'd1, "b", 1, {8{8'hFF}}, 8'h0E,
                    "aabbb", 5, 3, 32'h040302, 32'h040202);
        vt[6] = mkv(8'd2, "ab", 2, 64'h00FF, 8'hFF,
                    "azab", 4, 2, 32'h0301, 32'h0301);

        repeat (3) @(negedge aclk);
        tests++;
        if (m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_vld: got %b, want 0", m_axis_tvalid);
        end
        tests++;
        if (m_axis_tdata !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: got %h, want 00", m_axis_tdata);
        end
        aresetn = 1'b1;
        idle(2);
        got_q.delete();

        for (int n = 0; n < 7; n++) begin
            word_size   = vt[n].ws;
            characters  = mkw(vt[n].word, vt[n].wn);
            masks       = vt[n].mk;
            result_mask = vt[n].rm;
            flush();
            for (int c = 0; c < vt[n].tn; c++)
                send(1'b0, vt[n].txt[8*(vt[n].tn-1-c) +: 8]);
            idle(5);
            exp_q.delete();
            for (int j = 0; j < vt[n].en; j++) begin
                r.e = ce[vt[n].eidx[j]] + 1;
                r.d = vt[n].edat[j];
                exp_q.push_back(r);
            end
            check($sformatf("vec%0d", n));
        end

        word_size   = 8'd4;
        characters  = mkw("abcd", 4);
        masks       = {8{8'hFF}};
        result_mask = 8'hFF;
        flush();
        send(1'b0, "a");
        send(1'b0, "b");
        send(1'b1, 8'h00);
        send(1'b0, "c");
        send(1'b0, "d");
        idle(5);
`ifdef WORD_MATCHER_END_SENTINEL_EN
        expn = 1;
`else
        expn = 0;
`endif
        tests++;
        if (got_q.size() != expn) begin
            fails++;
            $display("FAIL fill_end_cnt: got %0d, want %0d",
                     got_q.size(), expn);
        end
        check("fill_end");

        word_size   = 8'd1;
        characters  = mkw("Q", 1);
        result_mask = 8'h0F;
        flush();
        for (int c = 0; c < 299; c++) send(1'b0, "a");
        send(1'b0, "Q");
        idle(5);
        tests++;
        if (got_q.size() != 1 || got_q[0].d != 8'h0B) begin
            fails++;
            $display("FAIL wrap: got %0d results first %h, want 1 x 0b",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].d : 8'h00);
        end
        check("wrap_model");

        characters  = mkw("Z", 1);
        result_mask = 8'hFF;
        flush();
        send(1'b0, "a");
        send(1'b0, "Z");
        @(negedge aclk);
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        idle(4);
        mtext.delete();
        mpos = 0;
        exp_q.delete();
        check("reset_drop");
        send(1'b0, "Z");
        idle(5);
        check("reset_pos0");

        ab   = '{"a", "A", "b", "B"};
        mopt = '{8'hFF, 8'hDF, 8'h00};
        for (int rd = 0; rd < 4; rd++) begin
            word_size   = 8'($urandom_range(0, 10));
            result_mask = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                characters[8*i +: 8] = ab[$urandom_range(0, 3)];
                k = $urandom_range(0, 5);
                masks[8*i +: 8] = (k < 3) ? mopt[k % 2] : mopt[2];
                if (k == 5) masks[8*i +: 8] = 8'($urandom);
            end
            flush();
            for (int b = 0; b < 80; b++) begin
                k = $urandom_range(0, 19);
                if (k == 0) begin
                    send(1'b1, 8'($urandom));
                end else if (k < 4) begin
                    @(negedge aclk);
                    s_axis_tvalid = 1'b0;
                    s_axis_tuser  = 1'($urandom);
                    s_axis_tdata  = 8'($urandom);
                end else begin
                    send(1'b0, ab[$urandom_range(0, 3)]);
                end
            end
            idle(5);
            check($sformatf("rand%0d", rd));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
